// File: rtl/tff_pkg.sv
// Shared constants, types and next-state helpers for the T-flip-flop counter.
// All arithmetic runs on MAX_WIDTH+1 bits, so a count never wraps silently at 2**WIDTH.
package tff_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef logic [MAX_WIDTH:0] count_t;

    function automatic count_t clamp_to_modulus(input count_t value, input count_t modulus);
        return (value >= modulus) ? (modulus - count_t'(1)) : value;
    endfunction

    function automatic count_t next_count(input count_t q, input logic up,
                                          input count_t modulus, input logic saturate);
        count_t top;
        top = modulus - count_t'(1);
        if (up) begin
            if (q == top) return saturate ? top : '0;
            return q + count_t'(1);
        end
        if (q == '0) return saturate ? '0 : top;
        return q - count_t'(1);
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles on t at each rising edge, async active-low clear.
module tff_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic t,
    output logic q
);

    logic r_q;

    // NOTE: sequential state uses non-blocking assignment so every cell samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_q <= 1'b0;
        else          r_q <= r_q ^ t;
    end

    assign q = r_q;

endmodule

// File: rtl/tff_counter.sv
// Up/down counter with modulus, wrap/saturate, load and clear, built from T cells.
// Next state is expressed only as a toggle vector t_vec = q ^ q_target.
module tff_counter
    import tff_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic [WIDTH-1:0] t_vec
);

    localparam count_t MOD_C = count_t'(MODULUS);
    localparam count_t TOP_C = MOD_C - count_t'(1);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("tff_counter: WIDTH out of range");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("tff_counter: MODULUS out of range");
    end

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_t_vec;
    count_t           w_q_ext;
    count_t           w_din_ext;
    count_t           w_target;
    logic             w_tc;
    logic             w_wrap_event;
    logic             r_wrap;

    assign w_q_ext   = count_t'(w_q);
    assign w_din_ext = count_t'(din);

    assign w_tc = en & ((up & (w_q_ext == TOP_C)) | (~up & (w_q_ext == '0)));

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        w_target     = w_q_ext;
        w_wrap_event = 1'b0;
        if (clr) begin
            w_target = '0;
        end else if (load) begin
            w_target = clamp_to_modulus(w_din_ext, MOD_C);
        end else if (en) begin
            w_target     = next_count(w_q_ext, up, MOD_C, SATURATE);
            w_wrap_event = !SATURATE && w_tc;
        end
    end

    assign w_t_vec = w_q ^ w_target[WIDTH-1:0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .t       (w_t_vec[i]),
            .q       (w_q[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_wrap <= 1'b0;
        else          r_wrap <= w_wrap_event;
    end

    // An out-of-range count or target means the next-state logic is broken.
    a_in_range: assert property (@(posedge clk) disable iff (!reset_n)
        (w_q_ext < MOD_C) && (w_target < MOD_C));

    assign q     = w_q;
    assign tc    = w_tc;
    assign wrap  = r_wrap;
    assign t_vec = w_t_vec;

endmodule

// File: doc/tff_counter.md
Name: tff_counter

Overview:
- Parametrised synchronous up/down counter built from a bank of T flip-flop cells.
- Successor to the single-bit toggle flop: adds width, modulus, direction, enable, load, clear, wrap/saturate mode and terminal-count flags.
- Used as a general event/divider counter in the day-to-day datapath blocks.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MODULUS, 2**WIDTH, count range 0..MODULUS-1. Legal range: 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- din  input  WIDTH  load value.
- q  output  WIDTH  counter value, registered.
- tc  output  1  combinational terminal count: en & ((up & q==MODULUS-1) | (~up & q==0)).
- wrap  output  1  registered one-cycle pulse after a wrap event.
- t_vec  output  WIDTH  per-bit toggle vector applied this cycle (debug/verification).

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset: reset_n=0 immediately forces q=0 and wrap=0, independent of clk. The first count takes place at the first rising edge after reset_n deasserts.
- Update rule: every bit is a T cell with q_next[i] = q[i] ^ t_vec[i]. All next-state logic is expressed as a toggle vector: t_vec = q ^ q_target.
- Priority at each rising edge is clr > load > en-count > hold.
  - clr=1: q_target = 0.
  - load=1: q_target = din. If din >= MODULUS, q_target = MODULUS-1 (clamp).
  - en=1, up=1: q_target = q+1. At q==MODULUS-1: 0 if SATURATE=0, else MODULUS-1.
  - en=1, up=0: q_target = q-1. At q==0: MODULUS-1 if SATURATE=0, else 0.
  - otherwise: t_vec = 0, so q holds.
- Width rule: internal arithmetic uses WIDTH+1 bits. There is no implicit modulo-2**WIDTH wrap except when MODULUS == 2**WIDTH.
- wrap: registered. It is 1 for exactly the cycle after an edge where the count wrapped (SATURATE=0 and tc=1, with no clr or load). It is never asserted in SATURATE=1 mode, or on clr/load.
- Latency: q changes 1 cycle after the controlling input is sampled. tc is combinational from q, en and up.
- Simultaneous events:
  - clr with load: clear wins.
  - load with en: load wins, no count that cycle.
  - A direction change takes effect the same cycle it is sampled.
- Reset mid-operation: asynchronous clear of q and wrap. Any in-flight load or count is discarded.
- Out-of-range state is unreachable. If q >= MODULUS is ever observed, that is a design bug and is flagged by an assertion.

Decomposition:
- Shared package tff_pkg:
  - constant for maximum supported WIDTH;
  - function clamp_to_modulus;
  - function next_count(q, up, modulus, saturate).
- One sub-module: tff_cell. It is a single T flip-flop with async active-low reset, input t, output q. tff_counter instantiates WIDTH copies through a generate loop.

Test Plan:
- Reset: hold reset_n=0 while toggling en/load for 3 clocks -> q=0, wrap=0. Assert reset_n=0 mid-cycle at q=5 -> q=0 immediately, before the next edge.
- WIDTH=4, MODULUS=10, SATURATE=0, up=1, en=1 for 12 clocks from 0 -> q = 1..9,0,1,2. tc=1 while q=9. wrap=1 for the single cycle where q=0 after 9.
- Same config, up=0 from q=0 -> q = 9,8,... and wrap pulses once. Then SATURATE=1, up=1 from q=8 for 3 clocks -> q = 9,9,9 with wrap=0 throughout.
- Load/clamp: load=1, din=7 -> q=7. load=1, din=13 (MODULUS=10) -> q=9.
- Priority: clr=1, load=1, din=5, en=1 -> q=0. Then load=1, din=5, en=1, up=1 -> q=5, not 6.
- Toggle check: WIDTH=8, default MODULUS, q=0x7F, up=1, en=1 -> t_vec=0xFF, next q=0x80. en=0 -> t_vec=0x00 and q holds for 4 clocks.
